i2c_sw_mirror_ctrl: RTL and testbench

Transaction sequencer sitting directly upstream of the I2C multi-slave system top, driving its master control interface (start/rw_bit/slave_addr/tx_data) and consuming its rx_data/busy/done/ack_error. Every poll period it reads the switch slave, then writes the value to the LED slave and to the FND slave. It handles NACK and timeout with bounded retry and keeps error statistics.

---
 rtl/i2c_sw_mirror_ctrl.sv | 93 +++++++++
 tb/tb_i2c_sw_mirror_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/i2c_sw_mirror_ctrl.sv
// i2c_sw_mirror_ctrl: polls the switch slave and mirrors its value to the LED and FND slaves with retry and error counting; SKIP_UNCHANGED_EN skips the writes when the value is unchanged
module i2c_sw_mirror_ctrl #(
  parameter int         POLL_CYCLES    = 1_000_000,
  parameter int         TIMEOUT_CYCLES = 50_000,
  parameter int         MAX_RETRY      = 2,
  parameter logic [6:0] ADDR_LED       = 7'h55,
  parameter logic [6:0] ADDR_FND       = 7'h56,
  parameter logic [6:0] ADDR_SW        = 7'h57
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       start,
  output logic       rw_bit,
  output logic [6:0] slave_addr,
  output logic [7:0] tx_data,
  input  logic [7:0] rx_data,
  input  logic       busy,
  input  logic       done,
  input  logic       ack_error,
  output logic [7:0] sw_value,
  output logic       round_done,
  output logic [7:0] err_count,
  output logic [2:0] debug_state
);
  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, RD_ISSUE, RD_WAIT, LED_ISSUE, LED_WAIT, FND_ISSUE, FND_WAIT
  } state_t;
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
  state_t state, state_n;
  logic [31:0] timer, wdog;
  logic [7:0] retry;
  logic issuing, in_wait, ok, fail, retry_ok, skip, rd_n;
`ifdef SKIP_UNCHANGED_EN
  logic round_seen;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) round_seen <= 1'b0;
    else if (rd_n) round_seen <= 1'b1;
  assign skip = state == RD_WAIT && round_seen && rx_data == sw_value;
`else
  assign skip = 1'b0;
`endif
  assign debug_state = state;
  always_comb begin
    issuing  = state inside {RD_ISSUE, LED_ISSUE, FND_ISSUE} && !busy;
    in_wait  = state inside {RD_WAIT, LED_WAIT, FND_WAIT};
    ok       = in_wait && done && !ack_error;
    fail     = in_wait && (done ? ack_error : wdog == TO_LAST);
    retry_ok = retry < RETRY_MAX;
    rd_n     = ok && enable && (state == FND_WAIT || skip);
    state_n  = state;
    case (state)
      IDLE:      state_n = enable ? RD_ISSUE : IDLE;
      WAIT_TICK: state_n = !enable ? IDLE : timer == POLL_LAST ? RD_ISSUE : WAIT_TICK;
      RD_ISSUE, LED_ISSUE, FND_ISSUE: state_n = busy ? state : state_t'(state + 3'd1);
      default:
        // a dropped enable only takes effect once the transaction and its retries settle
        if (fail) state_n = retry_ok ? state_t'(state - 3'd1) : enable ? WAIT_TICK : IDLE;
        else if (ok) state_n = !enable ? IDLE : (state == FND_WAIT || skip) ? WAIT_TICK : state_t'(state + 3'd1);
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start      <= 1'b0;
      rw_bit     <= 1'b0;
      slave_addr <= '0;
      tx_data    <= '0;
      sw_value   <= '0;
      round_done <= 1'b0;
      err_count  <= '0;
      timer      <= '0;
      wdog       <= '0;
      retry      <= '0;
    end else begin
      start      <= issuing;
      round_done <= rd_n;
      timer      <= (state == WAIT_TICK && state_n == WAIT_TICK) ? timer + 32'd1 : '0;
      wdog       <= in_wait ? wdog + 32'd1 : '0;
      retry      <= fail ? (retry_ok ? retry + 8'd1 : '0) : ok ? '0 : retry;
      if (fail && !retry_ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (ok && state == RD_WAIT) sw_value <= rx_data;
      if (issuing) begin
        rw_bit     <= state == RD_ISSUE;
        slave_addr <= state == RD_ISSUE ? ADDR_SW : state == LED_ISSUE ? ADDR_LED : ADDR_FND;
        tx_data    <= state == RD_ISSUE ? 8'h00 : sw_value;
      end
    end
endmodule

// File: tb/tb_i2c_sw_mirror_ctrl.sv
// tb_i2c_sw_mirror_ctrl: directed bench with a behavioural I2C master model and transaction log
module tb_i2c_sw_mirror_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic start, rw_bit, round_done, busy, done, ack_error;
  logic [6:0] slave_addr;
  logic [7:0] tx_data, rx_data, sw_value, err_count;
  logic [2:0] debug_state;
  int n_cmp = 0, n_err = 0, cyc = 0, tx_cnt = 0, rd_cnt = 0;
  int led_nack = 0, base, rd0;
  logic sw_nack = 1'b0, hang = 1'b0;
  logic [7:0] sw_in = 8'hA5;
  logic [6:0] log_addr [64];
  logic       log_rw   [64];
  logic [7:0] log_data [64];
  int         log_cyc  [64];
  i2c_sw_mirror_ctrl #(.POLL_CYCLES(100), .TIMEOUT_CYCLES(50), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .rw_bit(rw_bit),
    .slave_addr(slave_addr), .tx_data(tx_data), .rx_data(rx_data), .busy(busy),
    .done(done), .ack_error(ack_error), .sw_value(sw_value), .round_done(round_done),
    .err_count(err_count), .debug_state(debug_state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk); #1;
    if (round_done) rd_cnt++;
  end
  initial begin
    busy = 1'b0; done = 1'b0; ack_error = 1'b0; rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      done = 1'b0; ack_error = 1'b0;
      if (start) begin
        if (tx_cnt < 64) begin
          log_addr[tx_cnt] = slave_addr; log_rw[tx_cnt] = rw_bit;
          log_data[tx_cnt] = tx_data;    log_cyc[tx_cnt] = cyc;
        end
        tx_cnt++;
        if (!hang) begin
          busy = 1'b1;
          repeat (3) begin @(posedge clk); #1; end
          busy = 1'b0; done = 1'b1; rx_data = sw_in;
          ack_error = (slave_addr == 7'h57 && sw_nack) || (slave_addr == 7'h55 && led_nack > 0);
          if (slave_addr == 7'h55 && led_nack > 0) led_nack--;
        end
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_rd(input string tag, input int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (round_done) begin hit = 1'b1; break; end
    end
    check(tag, 64'(hit), 64'd1);
  endtask
  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (debug_state == s) begin hit = 1'b1; break; end
    end
    check(tag, 64'(hit), 64'd1);
  endtask
  task automatic wait_err(input string tag, input logic [7:0] n, input int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (err_count == n) begin hit = 1'b1; break; end
    end
    check(tag, 64'(hit), 64'd1);
  endtask
  task automatic wait_tx(input string tag, input int n, input int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (tx_cnt >= n) begin hit = 1'b1; break; end
    end
    check(tag, 64'(hit), 64'd1);
  endtask
  initial begin
    step(3);
    check("reset_outs", {start, rw_bit, slave_addr, tx_data, sw_value, round_done, err_count, debug_state}, 64'd0);
    rst_n = 1'b1; enable = 1'b1;
    wait_rd("r1_done_to", 500);
    check("r1_count", 64'(tx_cnt), 64'd3);
    check("r1_rd", {log_rw[0], log_addr[0]}, {1'b1, 7'h57});
    check("r1_led", {log_rw[1], log_addr[1], log_data[1]}, {1'b0, 7'h55, 8'hA5});
    check("r1_fnd", {log_rw[2], log_addr[2], log_data[2]}, {1'b0, 7'h56, 8'hA5});
    check("r1_sw", 64'(sw_value), 64'hA5);
    check("r1_state", 64'(debug_state), 64'd1);
    sw_in = 8'h5A; led_nack = 2; base = tx_cnt;
    step(99);
    check("tick_last", 64'(debug_state), 64'd1);
    step(1);
    check("tick_rd_issue", 64'(debug_state), 64'd2);
    step(1);
    check("tick_start", 64'(start), 64'd1);
    wait_rd("r2_done_to", 1000);
    check("r2_count", 64'(tx_cnt - base), 64'd5);
    check("r2_led_a", 64'(log_addr[base + 1]), 64'h55);
    check("r2_led_c", {log_addr[base + 3], log_data[base + 3]}, {7'h55, 8'h5A});
    check("r2_fnd", {log_addr[base + 4], log_data[base + 4]}, {7'h56, 8'h5A});
    check("r2_err", 64'(err_count), 64'd0);
    sw_nack = 1'b1; sw_in = 8'h77; base = tx_cnt; rd0 = rd_cnt;
    wait_err("r3_err_to", 8'd1, 1000);
    step(20);
    check("r3_count", 64'(tx_cnt - base), 64'd3);
    check("r3_all_rd", {log_addr[base], log_addr[base + 1], log_addr[base + 2]}, {7'h57, 7'h57, 7'h57});
    check("r3_sw_hold", 64'(sw_value), 64'h5A);
    check("r3_no_rd", 64'(rd_cnt - rd0), 64'd0);
    check("r3_state", 64'(debug_state), 64'd1);
    sw_nack = 1'b0; hang = 1'b1; base = tx_cnt;
    wait_err("r4_err_to", 8'd2, 2000);
    check("r4_count", 64'(tx_cnt - base), 64'd3);
    check("r4_gap", 64'(log_cyc[base + 1] - log_cyc[base]), 64'd51);
    check("r4_addr", 64'(log_addr[base + 2]), 64'h57);
    hang = 1'b0; sw_in = 8'hC3; base = tx_cnt; rd0 = rd_cnt;
    wait_state("r5_led_wait_to", 3'd5, 1000);
    enable = 1'b0;
    step(20);
    check("r5_count", 64'(tx_cnt - base), 64'd2);
    check("r5_led", {log_addr[base + 1], log_data[base + 1]}, {7'h55, 8'hC3});
    check("r5_idle", 64'(debug_state), 64'd0);
    check("r5_no_rd", 64'(rd_cnt - rd0), 64'd0);
    check("r5_err", 64'(err_count), 64'd2);
    enable = 1'b1;
    wait_state("r6_fnd_wait_to", 3'd7, 500);
    rst_n = 1'b0; #1;
    check("r6_async_rst", {start, rw_bit, slave_addr, tx_data, sw_value, round_done, err_count, debug_state}, 64'd0);
    sw_in = 8'h3C;
    step(3);
    rst_n = 1'b1; base = tx_cnt;
    wait_tx("r6_tx_to", base + 1, 200);
    check("r6_first_rd", {log_rw[base], log_addr[base]}, {1'b1, 7'h57});
    wait_rd("r7_done_to", 500);
    check("r7_count", 64'(tx_cnt - base), 64'd3);
    base = tx_cnt;
    wait_rd("r8_done_to", 500);
`ifdef SKIP_UNCHANGED_EN
    check("r8_skip_count", 64'(tx_cnt - base), 64'd1);
`else
    check("r8_full_count", 64'(tx_cnt - base), 64'd3);
`endif
    check("r8_sw", 64'(sw_value), 64'h3C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
